mdio_phy_responder: RTL and testbench
=====================================

// Module: mdio_phy_responder
// PURPOSE
//  PHY-side (responder) end of the IEEE 802.3 Clause 22 management interface driven by the MAC MDIO master.
//  Oversamples MDC/MDIO on sysck, decodes preamble/ST/OP/PHYAD/REGAD/TA/DATA, and serves a 32x16 register port.
//  Sits in the PHY model / loopback test harness and in any on-chip PHY shim behind the MDIO pins.
// PARAMETERS
//  PREAMBLE_MIN  32  consecutive 1s required before ST; 1..32
//  SYNC_STAGES   2   synchroniser depth on mdc_in/mdio_in; 2..3
//  BCAST_EN      0   1: PHYAD 5'h00 also accepted for writes (never for reads)
// PORTS
//  sysck      in   1   system clock; all logic on posedge
//  reset      in   1   one clock; reset is synchronous and active-high
//  phy_addr   in   5   strapped PHY address; sampled when the PHYAD field completes
//  mdc_in     in   1   MDC from master, asynchronous to sysck
//  mdio_in    in   1   MDIO pad input, asynchronous
//  mdio_o     out  1   MDIO pad output value
//  mdio_oe    out  1   MDIO pad output enable (1 = drive)
//  reg_addr   out  5   register address of current access (REGAD)
//  reg_wdata  out  16  write data; valid with reg_wr
//  reg_wr     out  1   1-cycle write strobe
//  reg_rd     out  1   1-cycle read request
//  reg_rdata  in   16  read data; must be valid 2 sysck after reg_rd, held until next reg_rd
//  frame_err  out  1   1-cycle pulse: bad ST or OP after valid preamble
//  busy       out  1   1 from ST detect until frame end (S_ST..S_SKIP)
// BEHAVIOUR
//  Reset: all outputs 0; state S_PRE; preamble count 0; edge-detect history loaded from synced inputs (no false edge).
//  Edges: rise/fall = synced MDC 0->1 / 1->0, one-cycle flags, SYNC_STAGES+1 sysck latency. Requires MDC half-period >= 4 sysck.
//  Sampling: mdio_in (synced) captured on every rise; all state transitions occur on rise.
//  Driving: mdio_o/mdio_oe change only on fall, registered (1 sysck after fall flag).
//  States:
//   S_PRE : 1 -> cnt=min(cnt+1,PREAMBLE_MIN); 0 with cnt==PREAMBLE_MIN -> S_ST (this 0 is ST bit0); 0 otherwise -> cnt=0.
//   S_ST  : expect 1 -> S_OP; else frame_err, cnt=0, S_PRE.
//   S_OP  : 2 bits; 10 = read, 01 = write -> S_PHY; 00/11 -> frame_err, cnt=0, S_PRE.
//   S_PHY : 5 bits MSB first; match = (PHYAD==phy_addr) | (BCAST_EN & write & PHYAD==0).
//   S_REG : 5 bits MSB first -> reg_addr. After 5th bit: match&read -> reg_rd pulse next cycle, S_TA;
//           match&write -> S_TA; no match -> S_SKIP (18 bits).
//   S_TA  : 2 bits. Read: reg_rdata latched into shift reg on TA bit0 rise; on following fall mdio_oe=1, mdio_o=0.
//           Write: TA values ignored (no error). -> S_DAT.
//   S_DAT : 16 bits. Read: each fall shifts out next bit MSB first; on fall after D0's rise mdio_oe=0, -> S_PRE.
//           Write: shift in on rise; after 16th bit reg_wdata updated and reg_wr pulses next cycle; -> S_PRE.
//   S_SKIP: count 18 rises, never drive; -> S_PRE.
//  Every frame end returns to S_PRE with cnt=0: a full new preamble is required (no preamble suppression).
//  Counters: 5-bit bit counter, reloaded on each state entry; preamble counter saturates (no wrap).
//  mdio_oe is asserted only in S_TA bit1 and S_DAT of a matched read; never in any other state.
//  reg_addr holds last REGAD until next REGAD completes; reg_wdata holds until next write.
//  reset mid-frame: mdio_oe drops the same cycle; no reg_wr/reg_rd issued; S_PRE, cnt=0.
//  MDC stopping mid-frame: state held indefinitely; mdio_oe held.
//  phy_addr changing mid-frame: affects only frames whose PHYAD completes after the change.
// TESTING
//  Write: 32x1, 01 01, PHYAD=phy_addr=5'h01, REGAD=5'h04, TA 10, data 16'hA5C3 -> one reg_wr, reg_addr=4, reg_wdata=A5C3, oe never 1.
//  Read: same header with OP 10, reg_rdata=16'h1234 -> one reg_rd, TA bit1 sampled 0, master shifts in 16'h1234, oe low after D0.
//  PHYAD=5'h02 vs phy_addr=5'h01, read -> no reg_rd, oe stays 0, next well-formed frame decoded.
//  31x1 preamble then write frame -> ignored; 33x1 preamble -> accepted.
//  ST=00 after 32x1 -> frame_err 1 pulse; OP=11 -> frame_err; then valid write -> reg_wr.
//  reset asserted at read data bit 5 -> oe=0 next cycle, busy=0; back-to-back read/write after release both served.

Source files
------------

// File: rtl/mdio_phy_responder_if.sv
// MDIO pin and register-port bundle for the Clause 22 PHY responder.
// slave = responder side, master = MAC/pad and register-file side.
interface mdio_phy_responder_if;
   logic [4:0]  phy_addr;
   logic        mdc_in;
   logic        mdio_in;
   logic        mdio_o;
   logic        mdio_oe;
   logic [4:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_wr;
   logic        reg_rd;
   logic [15:0] reg_rdata;
   logic        frame_err;
   logic        busy;

   modport slave (
      input  phy_addr, mdc_in, mdio_in, reg_rdata,
      output mdio_o, mdio_oe, reg_addr, reg_wdata, reg_wr, reg_rd, frame_err, busy
   );

   modport master (
      output phy_addr, mdc_in, mdio_in, reg_rdata,
      input  mdio_o, mdio_oe, reg_addr, reg_wdata, reg_wr, reg_rd, frame_err, busy
   );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO on sysck, decodes frames, serves a 32x16 register port.
// Edge flags lag MDC by SYNC_STAGES+1 sysck; no backpressure - reg_rdata must be valid 2 sysck after reg_rd.
module mdio_phy_responder #(
   parameter int PREAMBLE_MIN = 32,
   parameter int SYNC_STAGES  = 2,
   parameter int BCAST_EN     = 0
) (
   input  logic                  sysck,
   input  logic                  reset,
   mdio_phy_responder_if.slave   bus
);
   localparam int PW = 6;
   localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_MIN);

   typedef enum logic [2:0] {
      S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DAT, S_SKIP
   } state_t;

   logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
   logic mdc_prev, rise, fall, mdio_bit;

   state_t        state, state_nx;
   logic [PW-1:0] pre_cnt, pre_nx;
   logic [4:0]    bit_cnt, bit_nx, bit_inc, field;
   logic          op0, op0_nx, is_read, is_read_nx, matched, matched_nx;
   logic [3:0]    fld_sh, fld_nx;
   logic [4:0]    addr_q, addr_nx;
   logic [15:0]   sh, sh_nx, wdata_q, wdata_nx;
   logic          mdo_q, mdo_nx, oe_q, oe_nx;
   logic          wr_q, wr_nx, rd_q, rd_nx, err_q, err_nx;

   // Synchronisers run freely so the edge history can be preloaded during reset.
   always_ff @(posedge sysck) begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], bus.mdc_in};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], bus.mdio_in};
   end

   always_ff @(posedge sysck) begin
      mdc_prev <= mdc_sync[SYNC_STAGES-1];
      mdio_bit <= mdio_sync[SYNC_STAGES-1];
      if (reset) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
         fall <= ~mdc_sync[SYNC_STAGES-1] & mdc_prev;
      end
   end

   assign bit_inc = bit_cnt + 5'd1;
   assign field   = {fld_sh, mdio_bit};

   always_comb begin
      state_nx   = state;
      pre_nx     = pre_cnt;
      bit_nx     = bit_cnt;
      op0_nx     = op0;
      is_read_nx = is_read;
      matched_nx = matched;
      fld_nx     = fld_sh;
      addr_nx    = addr_q;
      sh_nx      = sh;
      wdata_nx   = wdata_q;
      mdo_nx     = mdo_q;
      oe_nx      = oe_q;
      wr_nx      = 1'b0;
      rd_nx      = 1'b0;
      err_nx     = 1'b0;
      if (rise) begin
         case (state)
            S_PRE: begin
               if (mdio_bit) begin
                  if (pre_cnt != PRE_MAX) pre_nx = pre_cnt + PW'(1);
               end else begin
                  if (pre_cnt == PRE_MAX) state_nx = S_ST;
                  pre_nx = '0;
               end
            end
            S_ST: begin
               bit_nx = '0;
               if (mdio_bit) begin
                  state_nx = S_OP;
               end else begin
                  err_nx   = 1'b1;
                  pre_nx   = '0;
                  state_nx = S_PRE;
               end
            end
            S_OP: begin
               if (bit_cnt == 5'd0) begin
                  op0_nx = mdio_bit;
                  bit_nx = 5'd1;
               end else if (op0 != mdio_bit) begin
                  is_read_nx = op0;
                  bit_nx     = '0;
                  state_nx   = S_PHY;
               end else begin
                  err_nx   = 1'b1;
                  pre_nx   = '0;
                  state_nx = S_PRE;
               end
            end
            S_PHY: begin
               fld_nx = field[3:0];
               bit_nx = bit_inc;
               if (bit_cnt == 5'd4) begin
                  matched_nx = (field == bus.phy_addr) ||
                               ((BCAST_EN != 0) && !is_read && (field == 5'd0));
                  bit_nx   = '0;
                  state_nx = S_REG;
               end
            end
            S_REG: begin
               fld_nx = field[3:0];
               bit_nx = bit_inc;
               if (bit_cnt == 5'd4) begin
                  addr_nx = field;
                  bit_nx  = '0;
                  if (matched) begin
                     rd_nx    = is_read;
                     state_nx = S_TA;
                  end else begin
                     state_nx = S_SKIP;
                  end
               end
            end
            S_TA: begin
               bit_nx = bit_inc;
               if (bit_cnt == 5'd0) begin
                  if (is_read) sh_nx = bus.reg_rdata;
               end else begin
                  bit_nx   = '0;
                  state_nx = S_DAT;
               end
            end
            S_DAT: begin
               bit_nx = bit_inc;
               if (!is_read) sh_nx = {sh[14:0], mdio_bit};
               if (bit_cnt == 5'd15) begin
                  pre_nx   = '0;
                  state_nx = S_PRE;
                  if (!is_read) begin
                     wdata_nx = {sh[14:0], mdio_bit};
                     wr_nx    = 1'b1;
                  end
               end
            end
            S_SKIP: begin
               bit_nx = bit_inc;
               if (bit_cnt == 5'd17) begin
                  pre_nx   = '0;
                  state_nx = S_PRE;
               end
            end
            default: state_nx = S_PRE;
         endcase
      end else if (fall) begin
         // Read frames end on D0's rise, so the release lands on the following fall in S_PRE.
         if (state == S_TA && bit_cnt == 5'd1 && is_read) begin
            oe_nx  = 1'b1;
            mdo_nx = 1'b0;
         end else if (state == S_DAT && is_read) begin
            oe_nx  = 1'b1;
            mdo_nx = sh[15];
            sh_nx  = {sh[14:0], 1'b0};
         end else begin
            oe_nx  = 1'b0;
            mdo_nx = 1'b0;
         end
      end
   end

   always_ff @(posedge sysck) begin
      if (reset) begin
         state   <= S_PRE;
         pre_cnt <= '0;
         bit_cnt <= '0;
         op0     <= 1'b0;
         is_read <= 1'b0;
         matched <= 1'b0;
         fld_sh  <= '0;
         addr_q  <= '0;
         sh      <= '0;
         wdata_q <= '0;
         mdo_q   <= 1'b0;
         oe_q    <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         pre_cnt <= pre_nx;
         bit_cnt <= bit_nx;
         op0     <= op0_nx;
         is_read <= is_read_nx;
         matched <= matched_nx;
         fld_sh  <= fld_nx;
         addr_q  <= addr_nx;
         sh      <= sh_nx;
         wdata_q <= wdata_nx;
         mdo_q   <= mdo_nx;
         oe_q    <= oe_nx;
         wr_q    <= wr_nx;
         rd_q    <= rd_nx;
         err_q   <= err_nx;
      end
   end

   assign bus.mdio_o    = mdo_q;
   assign bus.mdio_oe   = oe_q;
   assign bus.reg_addr  = addr_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.reg_wr    = wr_q;
   assign bus.reg_rd    = rd_q;
   assign bus.frame_err = err_q;
   assign bus.busy      = (state != S_PRE);
endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: an MDIO master drives frames, a scoreboard queue checks strobes.
module tb_mdio_phy_responder;
   localparam int HALF = 8;

   typedef struct {
      logic        is_wr;
      logic [4:0]  addr;
      logic [15:0] data;
   } exp_t;

   logic sysck = 1'b0;
   logic reset = 1'b1;
   logic master_oe = 1'b1;
   logic master_val = 1'b1;

   exp_t        exp_q[$];
   exp_t        e;
   int          checks = 0;
   int          failures = 0;
   int          err_cnt = 0;
   int          oe_cnt = 0;
   int          rd_delay = 0;
   logic [15:0] rd_value = 16'h0;

   mdio_phy_responder_if ifc ();

   mdio_phy_responder #(
      .PREAMBLE_MIN(32),
      .SYNC_STAGES (2),
      .BCAST_EN    (0)
   ) dut (
      .sysck(sysck),
      .reset(reset),
      .bus  (ifc)
   );

   always #5 sysck = ~sysck;

   // Open-drain style pad: master, responder, or pull-up.
   assign ifc.mdio_in = master_oe ? master_val : (ifc.mdio_oe ? ifc.mdio_o : 1'b1);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One sysck cycle, sampled on the falling edge; also the register-file model and scoreboard.
   task automatic tick();
      @(negedge sysck);
      if (reset) begin
         rd_delay = 0;
      end else begin
         if (rd_delay == 1) ifc.reg_rdata = rd_value;
         if (rd_delay > 0) rd_delay--;
         if (ifc.mdio_oe) oe_cnt++;
         if (ifc.frame_err) err_cnt++;
         if (ifc.reg_wr || ifc.reg_rd) begin
            if (ifc.reg_rd) begin
               ifc.reg_rdata = 16'hDEAD;
               rd_delay = 1;
            end
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", {30'd0, ifc.reg_wr, ifc.reg_rd}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("strobe_kind", {30'd0, ifc.reg_wr, ifc.reg_rd}, e.is_wr ? 32'd2 : 32'd1);
               check("strobe_addr", ifc.reg_addr, e.addr);
               if (e.is_wr) check("strobe_wdata", ifc.reg_wdata, e.data);
            end
         end
      end
   endtask

   task automatic mdc_bit(input logic b, input logic drive, output logic s);
      master_oe  = drive;
      master_val = b;
      repeat (HALF) tick();
      s = ifc.mdio_in;
      ifc.mdc_in = 1'b1;
      repeat (HALF) tick();
      ifc.mdc_in = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      logic s;
      for (int i = n - 1; i >= 0; i--) mdc_bit(v[i], 1'b1, s);
   endtask

   task automatic recv_bits(input int n, output logic [31:0] v);
      logic s;
      v = '0;
      for (int i = 0; i < n; i++) begin
         mdc_bit(1'b1, 1'b0, s);
         v = {v[30:0], s};
      end
      master_oe = 1'b1;
   endtask

   task automatic hdr(input int pre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra);
      for (int i = 0; i < pre; i++) send_bits(32'd1, 1);
      send_bits({18'd0, 2'b01, op, pa, ra}, 14);
   endtask

   task automatic write_frame(input int pre, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] d);
      hdr(pre, 2'b01, pa, ra);
      send_bits({14'd0, 2'b10, d}, 18);
   endtask

   task automatic read_frame(input int pre, input logic [4:0] pa, input logic [4:0] ra, output logic [31:0] got);
      hdr(pre, 2'b10, pa, ra);
      recv_bits(18, got);
   endtask

   initial begin
      logic [31:0] got;
      int oe0, err0;
      ifc.mdc_in    = 1'b0;
      ifc.phy_addr  = 5'h01;
      ifc.reg_rdata = 16'h0;
      reset = 1'b1;
      repeat (5) tick();
      check("rst_oe", ifc.mdio_oe, 0);
      check("rst_o", ifc.mdio_o, 0);
      check("rst_wr", ifc.reg_wr, 0);
      check("rst_rd", ifc.reg_rd, 0);
      check("rst_addr", ifc.reg_addr, 0);
      check("rst_wdata", ifc.reg_wdata, 0);
      check("rst_err", ifc.frame_err, 0);
      check("rst_busy", ifc.busy, 0);
      reset = 1'b0;
      repeat (4) tick();

      // Basic write.
      oe0 = oe_cnt;
      exp_q.push_back('{1'b1, 5'h04, 16'hA5C3});
      write_frame(32, 5'h01, 5'h04, 16'hA5C3);
      repeat (8) tick();
      check("wr_reg_addr", ifc.reg_addr, 5'h04);
      check("wr_reg_wdata", ifc.reg_wdata, 16'hA5C3);
      check("wr_oe_never", oe_cnt - oe0, 0);
      check("wr_busy_end", ifc.busy, 0);

      // Basic read.
      oe0 = oe_cnt;
      rd_value = 16'h1234;
      exp_q.push_back('{1'b0, 5'h04, 16'h0});
      read_frame(32, 5'h01, 5'h04, got);
      check("rd_ta", got[17:16], 2'b10);
      check("rd_data", got[15:0], 16'h1234);
      repeat (8) tick();
      check("rd_oe_released", ifc.mdio_oe, 0);
      check("rd_oe_driven", oe_cnt > oe0, 1);

      // Foreign PHYAD, then a normal write must still decode.
      oe0 = oe_cnt;
      read_frame(32, 5'h02, 5'h04, got);
      check("skip_pad_idle", got[17:0], 18'h3FFFF);
      check("skip_oe_never", oe_cnt - oe0, 0);
      exp_q.push_back('{1'b1, 5'h05, 16'h1357});
      write_frame(32, 5'h01, 5'h05, 16'h1357);
      repeat (8) tick();
      check("post_skip_wdata", ifc.reg_wdata, 16'h1357);

      // Short preamble ignored, long preamble accepted.
      write_frame(31, 5'h01, 5'h06, 16'h5A5A);
      repeat (8) tick();
      check("pre31_ignored", ifc.reg_wdata, 16'h1357);
      exp_q.push_back('{1'b1, 5'h06, 16'h5A5A});
      write_frame(33, 5'h01, 5'h06, 16'h5A5A);
      repeat (8) tick();
      check("pre33_wdata", ifc.reg_wdata, 16'h5A5A);

      // Bad ST, bad OP, then recovery.
      err0 = err_cnt;
      for (int i = 0; i < 32; i++) send_bits(32'd1, 1);
      send_bits(32'b00, 2);
      repeat (8) tick();
      check("err_st", err_cnt - err0, 1);
      check("err_st_busy", ifc.busy, 0);
      for (int i = 0; i < 32; i++) send_bits(32'd1, 1);
      send_bits(32'b0111, 4);
      repeat (8) tick();
      check("err_op", err_cnt - err0, 2);
      exp_q.push_back('{1'b1, 5'h08, 16'hC0DE});
      write_frame(32, 5'h01, 5'h08, 16'hC0DE);
      repeat (8) tick();
      check("err_recover_wdata", ifc.reg_wdata, 16'hC0DE);

      // Reset in the middle of read data.
      rd_value = 16'h4321;
      exp_q.push_back('{1'b0, 5'h03, 16'h0});
      hdr(32, 2'b10, 5'h01, 5'h03);
      recv_bits(7, got);
      check("abort_partial", got[6:0], 7'b1001000);
      check("abort_oe_before", ifc.mdio_oe, 1);
      reset = 1'b1;
      tick();
      check("abort_oe_drop", ifc.mdio_oe, 0);
      check("abort_busy_drop", ifc.busy, 0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (4) tick();

      // Back-to-back read and write after reset.
      rd_value = 16'hBEEF;
      exp_q.push_back('{1'b0, 5'h07, 16'h0});
      read_frame(32, 5'h01, 5'h07, got);
      check("b2b_rd_data", got[15:0], 16'hBEEF);
      exp_q.push_back('{1'b1, 5'h09, 16'h0F0F});
      write_frame(32, 5'h01, 5'h09, 16'h0F0F);
      repeat (8) tick();
      check("b2b_wr_addr", ifc.reg_addr, 5'h09);
      check("b2b_wr_wdata", ifc.reg_wdata, 16'h0F0F);
      check("sb_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
